fpu_arbiter: RTL
================

Name: fpu_arbiter

Overview:
- Shares the single FPU instance (operator/subop/a/b in, result_valid/c out) between NUM_REQ requesters: CPU EX stage, future vector/float-loader units.
- Round-robin arbitration, one operation in flight, FPU result routed back to the issuing requester.
- Per-operation watchdog so a hung FPU cannot deadlock the core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, cycles in WAIT before the operation is aborted with an error.
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden).

Ports:
- CLK  in  1  system clock.
- INITIALIZE_N  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready.
- req_operator  in  3*NUM_REQ  packed FPU operator, slice i belongs to requester i.
- req_subop  in  3*NUM_REQ  packed FPU subop.
- req_a  in  32*NUM_REQ  packed operand a.
- req_b  in  32*NUM_REQ  packed operand b.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- resp_c  out  32  result data, valid with resp_valid.
- resp_err  out  1  qualifies resp_valid: 1 = timeout, resp_c = 0.
- fpu_in_valid  out  1  one-cycle issue pulse to FPU.
- fpu_operator  out  3  latched operator.
- fpu_subop  out  3  latched subop.
- fpu_a  out  32  latched operand a.
- fpu_b  out  32  latched operand b.
- fpu_result_valid  in  1  FPU completion pulse.
- fpu_c  in  32  FPU result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, INITIALIZE_N low): state IDLE; all outputs 0; rr_ptr = NUM_REQ-1, so requester 0 has first priority; watchdog = 0.
- All outputs are registered.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
  - Latch the grant's operator/subop/a/b into fpu_* and store grant index g.
  - Pulse req_ready[g] for that cycle, set rr_ptr = g, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: fpu_in_valid = 1 for exactly this cycle; watchdog cleared; go to WAIT.
- WAIT:
  - fpu_result_valid = 1: capture fpu_c into resp_c, resp_err = 0, go to RESP.
  - Otherwise increment watchdog. On reaching TIMEOUT-1 with no result: resp_c = 0, resp_err = 1, go to RESP.
- RESP: resp_valid[g] = 1 for one cycle, then IDLE. resp_c/resp_err hold their values until the next RESP.
- Latency: accept at cycle T, fpu_in_valid at T+1. For FPU latency L (result_valid at T+1+L), resp_valid occurs at T+2+L. Minimum request-to-request turnaround is 4 cycles.
- fpu_result_valid in IDLE, ISSUE or RESP is stale and ignored. This includes a late result after a timeout.
- Operands are captured at accept. Requester changes after req_ready have no effect on the operation in flight.
- A requester deasserting req_valid before it is granted is legal; no state is kept for it.
- fpu_operator/subop/a/b hold their last values outside ISSUE.
- Reset asserted mid-operation: immediate return to the reset state, no resp_valid pulse. The FPU's own INITIALIZE clears its pipeline.
- Watchdog is IDX-independent, width $clog2(TIMEOUT)+1, and saturates; no wrap-around.

Optional Feature:
- FPU_ARB_STATS_EN defined:
  - Adds outputs stat_grants (32*NUM_REQ, packed per-requester accepted-op counters) and stat_timeouts (16).
  - Counters are saturating and reset to 0.
  - stat_grants[i] increments on req_ready[i]; stat_timeouts increments on each resp_err pulse.
- Not defined: the ports and counters are absent; no other behaviour changes.

Test Plan:
- Single op: FPU model latency 3; req0 ADD a=0x3F800000, b=0x40000000 at T -> req_ready[0]@T, fpu_in_valid@T+1, resp_valid[0]@T+5, resp_c=0x40400000, resp_err=0.
- Contention: req0 and req1 held continuously after reset -> grant order 0,1,0,1. Each resp_valid goes only to its issuer, and no fpu_in_valid occurs while busy.
- Timeout (TIMEOUT=64): FPU never responds -> resp_valid[g] with resp_err=1 and resp_c=0 exactly 64 cycles after fpu_in_valid. A result_valid injected 5 cycles later is ignored, and the next op completes normally.
- Operand stability: req1 changes req_a to 0xDEADBEEF the cycle after req_ready[1] -> fpu_a still shows the accepted value; result matches the original operands.
- Reset mid-WAIT: INITIALIZE_N low for 1 cycle during WAIT -> all outputs 0 asynchronously, no resp_valid, rr_ptr restored so req0 wins next.
- With FPU_ARB_STATS_EN: 3 ops from req0, 2 from req1, 1 timeout -> stat_grants = {2,3}, stat_timeouts = 1.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NUM_REQ requesters; accept->resp is 2+L cycles for FPU latency L.
// One op in flight: req_ready only pulses in IDLE, and a watchdog aborts hung ops. FPU_ARB_STATS_EN adds counters.
module fpu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WD_W  = $clog2(TIMEOUT) + 1
) (
    input  logic                   CLK,
    input  logic                   INITIALIZE_N,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [3*NUM_REQ-1:0]   req_operator,
    input  logic [3*NUM_REQ-1:0]   req_subop,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_c,
    output logic                   resp_err,
    output logic                   fpu_in_valid,
    output logic [2:0]             fpu_operator,
    output logic [2:0]             fpu_subop,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    input  logic                   fpu_result_valid,
    input  logic [31:0]            fpu_c,
`ifdef FPU_ARB_STATS_EN
    output logic [32*NUM_REQ-1:0]  stat_grants,
    output logic [15:0]            stat_timeouts,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_gnt;
    logic [WD_W-1:0]      r_wd;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [31:0]          r_resp_c;
    logic                 r_resp_err;
    logic                 r_fpu_in_valid;
    logic [2:0]           r_fpu_operator;
    logic [2:0]           r_fpu_subop;
    logic [31:0]          r_fpu_a;
    logic [31:0]          r_fpu_b;
    logic                 r_busy;

    logic                 w_gnt_vld;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic [NUM_REQ-1:0]   w_rsp_oh;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Scan farthest-to-nearest from rr_ptr so the nearest requester assigns last and wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDX_W'(idx);
            end
        end
    end

    assign w_gnt_oh = ONE_HOT0 << w_gnt_idx;
    assign w_rsp_oh = ONE_HOT0 << r_gnt;

    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= IDX_W'(NUM_REQ - 1);
            r_gnt          <= '0;
            r_wd           <= '0;
            r_req_ready    <= '0;
            r_resp_valid   <= '0;
            r_resp_c       <= '0;
            r_resp_err     <= 1'b0;
            r_fpu_in_valid <= 1'b0;
            r_fpu_operator <= '0;
            r_fpu_subop    <= '0;
            r_fpu_a        <= '0;
            r_fpu_b        <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_req_ready    <= '0;
            r_resp_valid   <= '0;
            r_fpu_in_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_fpu_operator <= req_operator[3*w_gnt_idx +: 3];
                        r_fpu_subop    <= req_subop[3*w_gnt_idx +: 3];
                        r_fpu_a        <= req_a[32*w_gnt_idx +: 32];
                        r_fpu_b        <= req_b[32*w_gnt_idx +: 32];
                        r_gnt          <= w_gnt_idx;
                        r_rr_ptr       <= w_gnt_idx;
                        r_req_ready    <= w_gnt_oh;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_fpu_in_valid <= 1'b1;
                    r_wd           <= '0;
                    r_state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpu_result_valid) begin
                        r_resp_c     <= fpu_c;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= w_rsp_oh;
                        r_state      <= S_RESP;
                    end else if (r_wd >= WD_W'(TIMEOUT - 1)) begin
                        r_resp_c     <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= w_rsp_oh;
                        r_state      <= S_RESP;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_c       = r_resp_c;
    assign resp_err     = r_resp_err;
    assign fpu_in_valid = r_fpu_in_valid;
    assign fpu_operator = r_fpu_operator;
    assign fpu_subop    = r_fpu_subop;
    assign fpu_a        = r_fpu_a;
    assign fpu_b        = r_fpu_b;
    assign busy         = r_busy;

`ifdef FPU_ARB_STATS_EN
    logic [32*NUM_REQ-1:0] r_stat_grants;
    logic [15:0]           r_stat_timeouts;

    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            r_stat_grants   <= '0;
            r_stat_timeouts <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_req_ready[i] && (r_stat_grants[32*i +: 32] != 32'hFFFF_FFFF))
                    r_stat_grants[32*i +: 32] <= r_stat_grants[32*i +: 32] + 32'd1;
            end
            if ((|r_resp_valid) && r_resp_err && (r_stat_timeouts != 16'hFFFF))
                r_stat_timeouts <= r_stat_timeouts + 16'd1;
        end
    end

    assign stat_grants   = r_stat_grants;
    assign stat_timeouts = r_stat_timeouts;
`endif

endmodule
